regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Merges N_SRC writeback streams into the single write port (waddr/we/wdata) of the
//   physical register file. Each source has a small FIFO. A round-robin arbiter drains
//   one entry per cycle into a registered output stage that drives the register file.
//   Sits between the execute/writeback pipes and the register file.
// PARAMETERS
//   N_SRC       2   number of writeback sources (>=1)
//   DATA_WIDTH  32  register data width
//   DEPTH       64  register file entries
//   ADDR_DEPTH  (DEPTH>1)?$clog2(DEPTH):1  write address width (derived)
//   Q_DEPTH     2   per-source FIFO entries (power of two, >=2)
// PORTS
//   clk          in   1                    clock
//   rst_n        in   1                    async reset, active low
//   src_valid_i  in   N_SRC                source i presents a write
//   src_ready_o  out  N_SRC                source i FIFO can accept
//   src_waddr_i  in   N_SRC x ADDR_DEPTH   write address per source
//   src_wdata_i  in   N_SRC x DATA_WIDTH   write data per source
//   flush_i      in   1                    discard all pending writes
//   we_o         out  1                    to register file we_i
//   waddr_o      out  ADDR_DEPTH           to register file waddr_i
//   wdata_o      out  DATA_WIDTH           to register file wdata_i
//   busy_o       out  1                    any FIFO non-empty or we_o high
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-low (rst_n). On reset: FIFOs empty,
//     rr_ptr=0, we_o=0, waddr_o=0, wdata_o=0, busy_o=0.
//   - Accept: src_valid_i[i] & src_ready_o[i] at a rising edge pushes {waddr,wdata}.
//     src_ready_o[i] = ~full[i] & ~flush_i. It depends only on state and flush_i, never on
//     src_valid_i. A full FIFO stays not-ready even if it pops that same cycle.
//   - Arbiter: each cycle, scan FIFOs from rr_ptr upward, mod N_SRC. The first non-empty
//     FIFO is granted and popped at the edge. rr_ptr <= grant+1 (mod N_SRC). rr_ptr holds
//     when there is no grant.
//   - Output stage registered: we_o<=grant_valid; waddr_o/wdata_o load only when granted,
//     hold otherwise. Exactly one register-file write per cycle maximum.
//   - Latency: accept at edge t -> FIFO head at t+1 -> pop at edge t+1 -> we_o high in
//     cycle t+2 (2 cycles) when uncontended.
//   - Order: FIFO order kept per source; no order across sources. Upstream guarantees
//     destination uniqueness (renamed phys regs). Same addr from 2 sources is written in
//     grant order.
//   - flush_i: at the edge, all FIFOs are emptied, rr_ptr<=0, we_o<=0. Accepts in the flush
//     cycle are dropped because ready is low. A write already on we_o during the flush cycle
//     still completes.
//   - FIFO pointers are Q_DEPTH-wrapping with an extra wrap bit for full/empty.
//     Simultaneous push and pop on a non-full FIFO keeps the count.
//   - Reset mid-operation drops all pending entries; outputs go to 0 immediately.
// CONFIGURATION
//   REGFILE_WQ_BYPASS_EN
//     Defined:   when all FIFOs are empty, the valid source chosen by rr order from rr_ptr
//                skips its FIFO and loads the output stage directly. This gives 1-cycle
//                latency and advances rr_ptr. Other valid sources enqueue normally. flush_i
//                suppresses the bypass.
//     Undefined: every write goes through its FIFO (fixed 2-cycle latency).
// TESTING
//   1 src0 writes addr 5, data 0xDEADBEEF at t -> we_o=1, waddr_o=5, wdata_o=0xDEADBEEF in
//     cycle t+2 (t+1 with BYPASS_EN), one cycle only.
//   2 N_SRC=2, both valid every cycle for 8 cycles -> we_o every cycle, source order
//     0,1,0,1; no entry lost or duplicated.
//   3 N_SRC=3, all valid, Q_DEPTH=2 -> ready drops on the full FIFOs. Total we_o pulses equal
//     total accepts, and per-source data order is preserved.
//   4 Load 2 entries into src0, assert flush_i before they drain -> at most the in-flight
//     we_o completes; no later writes; busy_o=0 two cycles after flush.
//   5 Assert rst_n=0 while we_o=1 and FIFOs are non-empty -> we_o/waddr_o/wdata_o=0 at once.
//     After release, src_ready_o is all 1 and no stale writes occur.
//   6 Hold src1 valid with a full FIFO while src0 is idle -> src1 is granted every cycle and
//     ready re-asserts the cycle after the first pop.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Merges N_SRC writeback streams into the single register-file write port through per-source
// FIFOs and a round-robin drain. Define REGFILE_WQ_BYPASS_EN for 1-cycle bypass when all FIFOs are empty.
module regfile_write_arbiter #(
  parameter int N_SRC      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int Q_DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SRC-1:0]            src_valid_i,
  output logic [N_SRC-1:0]            src_ready_o,
  input  logic [N_SRC*ADDR_DEPTH-1:0] src_waddr_i,
  input  logic [N_SRC*DATA_WIDTH-1:0] src_wdata_i,
  input  logic                        flush_i,
  output logic                        we_o,
  output logic [ADDR_DEPTH-1:0]       waddr_o,
  output logic [DATA_WIDTH-1:0]       wdata_o,
  output logic                        busy_o
);
  localparam int PW = $clog2(Q_DEPTH);
  localparam int RW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [PW:0] PTR_ONE = 1;
  localparam logic [RW-1:0] RR_ONE = 1;

  logic [ADDR_DEPTH-1:0] q_addr [N_SRC][Q_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [N_SRC][Q_DEPTH];
  logic [PW:0]           wr_ptr [N_SRC];
  logic [PW:0]           rd_ptr [N_SRC];
  logic [N_SRC-1:0]      empty, full, push, pop;
  logic [RW-1:0]         rr_ptr, grant_idx, rr_next;
  logic                  grant_valid, bypass;
  logic [ADDR_DEPTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic int wrap_src(int base, int k);
    int s;
    s = base + k;
    if (s >= N_SRC) s = s - N_SRC;
    return s;
  endfunction

  // Pointers carry one extra wrap bit so equal low bits distinguish full from empty.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][PW] != rd_ptr[i][PW]) && (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
    end
  end

  assign src_ready_o = ~full & {N_SRC{~flush_i}};
  assign busy_o      = (|(~empty)) | we_o;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    bypass      = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!grant_valid && !empty[wrap_src(int'(rr_ptr), k)]) begin
        grant_valid = 1'b1;
        grant_idx   = RW'(wrap_src(int'(rr_ptr), k));
      end
    end
`ifdef REGFILE_WQ_BYPASS_EN
    if (&empty && !flush_i) begin
      for (int k = 0; k < N_SRC; k++) begin
        if (!grant_valid && src_valid_i[wrap_src(int'(rr_ptr), k)]) begin
          grant_valid = 1'b1;
          grant_idx   = RW'(wrap_src(int'(rr_ptr), k));
          bypass      = 1'b1;
        end
      end
    end
`endif
    rr_next = (int'(grant_idx) == N_SRC - 1) ? '0 : grant_idx + RR_ONE;
  end

  always_comb begin
    sel_addr = q_addr[grant_idx][rd_ptr[grant_idx][PW-1:0]];
    sel_data = q_data[grant_idx][rd_ptr[grant_idx][PW-1:0]];
    if (bypass) begin
      sel_addr = src_waddr_i[int'(grant_idx)*ADDR_DEPTH +: ADDR_DEPTH];
      sel_data = src_wdata_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A bypassed source must not also be enqueued.
  always_comb begin
    push = src_valid_i & src_ready_o;
    pop  = '0;
    if (grant_valid && !flush_i) begin
      if (bypass) push[grant_idx] = 1'b0;
      else        pop[grant_idx]  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
      end
      if (grant_valid) rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) begin
        q_addr[i][wr_ptr[i][PW-1:0]] <= src_waddr_i[i*ADDR_DEPTH +: ADDR_DEPTH];
        q_data[i][wr_ptr[i][PW-1:0]] <= src_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Address/data hold between writes; only the strobe drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else begin
      we_o <= grant_valid & ~flush_i;
      if (grant_valid && !flush_i) begin
        waddr_o <= sel_addr;
        wdata_o <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (3 sources, 2-entry FIFOs); follows REGFILE_WQ_BYPASS_EN.
module tb_regfile_write_arbiter;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int QD = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*AW-1:0] src_waddr;
  logic [NS*DW-1:0] src_wdata;
  logic             flush_i;
  logic             we_o;
  logic [AW-1:0]    waddr_o;
  logic [DW-1:0]    wdata_o;
  logic             busy_o;

  int compared = 0;
  int mismatched = 0;

  logic [AW+DW-1:0] mq [NS][$];
  int               m_rr = 0;
  logic             m_we = 1'b0;
  logic [AW-1:0]    m_addr = '0;
  logic [DW-1:0]    m_data = '0;
  int               m_accepts = 0;
  logic [DW-1:0]    wlog [$];

  regfile_write_arbiter #(.N_SRC(NS), .DATA_WIDTH(DW), .DEPTH(64), .Q_DEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_waddr_i(src_waddr), .src_wdata_i(src_wdata), .flush_i(flush_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] modelReady();
    logic [NS-1:0] r;
    for (int s = 0; s < NS; s++) r[s] = (mq[s].size() < QD) && !flush_i;
    return r;
  endfunction

  function automatic logic modelBusy();
    logic b;
    b = m_we;
    for (int s = 0; s < NS; s++) if (mq[s].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic modelReset();
    for (int s = 0; s < NS; s++) mq[s].delete();
    m_rr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
  endtask

  // Reference: queues per source, round-robin over queue occupancy, one write per edge.
  task automatic modelStep();
    int g;
    bit byp;
    bit all_empty;
    bit acc [NS];
    if (flush_i) begin
      for (int s = 0; s < NS; s++) mq[s].delete();
      m_rr = 0;
      m_we = 1'b0;
      return;
    end
    g = -1; byp = 0; all_empty = 1;
    for (int s = 0; s < NS; s++) if (mq[s].size() != 0) all_empty = 0;
    for (int k = 0; k < NS; k++) if (g < 0 && mq[(m_rr + k) % NS].size() != 0) g = (m_rr + k) % NS;
`ifdef REGFILE_WQ_BYPASS_EN
    if (all_empty)
      for (int k = 0; k < NS; k++)
        if (g < 0 && src_valid[(m_rr + k) % NS]) begin g = (m_rr + k) % NS; byp = 1; end
`endif
    for (int s = 0; s < NS; s++) acc[s] = src_valid[s] && (mq[s].size() < QD) && !(byp && g == s);
    if (g >= 0) begin
      m_we = 1'b1;
      if (byp) {m_addr, m_data} = {src_waddr[g*AW +: AW], src_wdata[g*DW +: DW]};
      else     {m_addr, m_data} = mq[g].pop_front();
      m_rr = (g + 1) % NS;
    end else begin
      m_we = 1'b0;
    end
    for (int s = 0; s < NS; s++)
      if (acc[s]) begin
        mq[s].push_back({src_waddr[s*AW +: AW], src_wdata[s*DW +: DW]});
        m_accepts++;
      end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) modelReset();
    else        modelStep();
  end

  initial forever begin
    @(negedge clk);
    checkOutput("we_o", 32'(we_o), 32'(m_we));
    checkOutput("waddr_o", 32'(waddr_o), 32'(m_addr));
    checkOutput("wdata_o", wdata_o, m_data);
    checkOutput("busy_o", 32'(busy_o), 32'(modelBusy()));
    checkOutput("src_ready_o", 32'(src_ready), 32'(modelReady()));
    if (we_o) wlog.push_back(wdata_o);
  end

  task automatic applyStimulus(input logic [NS-1:0] valid, input logic flush, input int tag, input int idx);
    @(posedge clk); #1;
    src_valid = valid;
    flush_i = flush;
    for (int s = 0; s < NS; s++) begin
      src_waddr[s*AW +: AW] = AW'((s * 16 + idx) % 64);
      src_wdata[s*DW +: DW] = {8'(tag), 8'(s), 16'(idx)};
    end
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int start, acc0, last [NS];
    bit ordered;
    logic [DW-1:0] d;
    src_valid = '0; flush_i = 1'b0; src_waddr = '0; src_wdata = '0;

    #12;
    checkOutput("rst_we", 32'(we_o), 32'd0);
    checkOutput("rst_waddr", 32'(waddr_o), 32'd0);
    checkOutput("rst_wdata", wdata_o, 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk); #2; rst_n = 1'b1;

    // single write from src0
    @(posedge clk); #1;
    src_valid = 3'b001; src_waddr[0 +: AW] = 6'd5; src_wdata[0 +: DW] = 32'hDEADBEEF;
    applyStimulus('0, 1'b0, 0, 0);
`ifdef REGFILE_WQ_BYPASS_EN
    waitNeg(1);
`else
    waitNeg(1);
    checkOutput("t1_early_we", 32'(we_o), 32'd0);
    waitNeg(1);
`endif
    checkOutput("t1_we", 32'(we_o), 32'd1);
    checkOutput("t1_waddr", 32'(waddr_o), 32'd5);
    checkOutput("t1_wdata", wdata_o, 32'hDEADBEEF);
    waitNeg(1);
    checkOutput("t1_we_one_cycle", 32'(we_o), 32'd0);

    // two sources streaming
    applyStimulus('0, 1'b1, 0, 0);
    start = wlog.size();
    for (int k = 0; k < 8; k++) applyStimulus(3'b011, 1'b0, 8'hA0, k);
    applyStimulus('0, 1'b0, 0, 0);
    waitNeg(12);
`ifdef REGFILE_WQ_BYPASS_EN
    checkOutput("t2_count", 32'(wlog.size() - start), 32'd11);
`else
    checkOutput("t2_count", 32'(wlog.size() - start), 32'd10);
`endif
    checkOutput("t2_w0", wlog[start], 32'hA0000000);
    checkOutput("t2_w1", wlog[start+1], 32'hA0010000);
    checkOutput("t2_w2", wlog[start+2], 32'hA0000001);
    checkOutput("t2_w3", wlog[start+3], 32'hA0010001);

    // three sources contending
    applyStimulus('0, 1'b1, 0, 0);
    start = wlog.size();
    acc0 = m_accepts;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(3'b111, 1'b0, 8'hB0, k);
      @(negedge clk);
`ifdef REGFILE_WQ_BYPASS_EN
      if (k == 2) checkOutput("t3_ready", 32'(src_ready), 32'b011);
`else
      if (k == 2) checkOutput("t3_ready", 32'(src_ready), 32'b001);
`endif
    end
    applyStimulus('0, 1'b0, 0, 0);
    waitNeg(12);
    checkOutput("t3_count", 32'(wlog.size() - start), 32'(m_accepts - acc0));
    ordered = 1;
    for (int s = 0; s < NS; s++) last[s] = -1;
    for (int i = start; i < wlog.size(); i++) begin
      d = wlog[i];
      if (d[31:24] == 8'hB0) begin
        if (int'(d[15:0]) <= last[d[23:16]]) ordered = 0;
        last[d[23:16]] = int'(d[15:0]);
      end
    end
    checkOutput("t3_order", 32'(ordered), 32'd1);

    // flush with pending entries
    start = wlog.size();
    applyStimulus(3'b001, 1'b0, 8'hC0, 0);
    applyStimulus(3'b001, 1'b0, 8'hC0, 1);
    applyStimulus(3'b001, 1'b1, 8'hC0, 2);
    @(negedge clk);
    checkOutput("t4_inflight_we", 32'(we_o), 32'd1);
    checkOutput("t4_flush_ready", 32'(src_ready), 32'd0);
    applyStimulus('0, 1'b0, 0, 0);
    @(negedge clk);
    checkOutput("t4_we_after", 32'(we_o), 32'd0);
    checkOutput("t4_busy_after", 32'(busy_o), 32'd0);
    waitNeg(4);
`ifdef REGFILE_WQ_BYPASS_EN
    checkOutput("t4_count", 32'(wlog.size() - start), 32'd2);
`else
    checkOutput("t4_count", 32'(wlog.size() - start), 32'd1);
`endif

    // reset mid-operation
    applyStimulus(3'b011, 1'b0, 8'hD0, 0);
    applyStimulus(3'b011, 1'b0, 8'hD0, 1);
    applyStimulus(3'b011, 1'b0, 8'hD0, 2);
    @(negedge clk);
    checkOutput("t5_pre_we", 32'(we_o), 32'd1);
    checkOutput("t5_pre_busy", 32'(busy_o), 32'd1);
    #2; rst_n = 1'b0; src_valid = '0;
    #1;
    checkOutput("t5_rst_we", 32'(we_o), 32'd0);
    checkOutput("t5_rst_waddr", 32'(waddr_o), 32'd0);
    checkOutput("t5_rst_wdata", wdata_o, 32'd0);
    checkOutput("t5_rst_busy", 32'(busy_o), 32'd0);
    waitNeg(2); #2; rst_n = 1'b1;
    start = wlog.size();
    waitNeg(5);
    checkOutput("t5_ready", 32'(src_ready), 32'b111);
    checkOutput("t5_no_stale", 32'(wlog.size() - start), 32'd0);

    // src1 held valid against a full FIFO
    applyStimulus('0, 1'b1, 0, 0);
    for (int k = 0; k < 14; k++) begin
      applyStimulus((k < 4) ? 3'b111 : 3'b010, 1'b0, 8'hE0, k);
      @(negedge clk);
`ifdef REGFILE_WQ_BYPASS_EN
      if (k == 4) checkOutput("t6_full_ready", 32'(src_ready[1]), 32'd0);
      if (k == 5) checkOutput("t6_reready", 32'(src_ready[1]), 32'd1);
`else
      if (k == 5) checkOutput("t6_full_ready", 32'(src_ready[1]), 32'd0);
      if (k == 6) checkOutput("t6_reready", 32'(src_ready[1]), 32'd1);
`endif
      if (k >= 12) begin
        checkOutput("t6_steady_we", 32'(we_o), 32'd1);
        checkOutput("t6_steady_src", 32'(wdata_o[23:16]), 32'd1);
        checkOutput("t6_steady_ready", 32'(src_ready), 32'b111);
      end
    end
    applyStimulus('0, 1'b0, 0, 0);
    waitNeg(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
